lga_ppg_window: RTL and testbench

- Parametrised successor of the three-row propagation line buffer for the FHP lattice-gas engine.
- Streams lattice rows in from VRAM and keeps a three-slot row ring, with three address-shifted RAM copies per slot.
- Emits, for every cell, a registered 3x3 neighbourhood window (9×DW) to the downstream propagation/collision logic.
- Adds over the previous generation: parametric width/depth, valid/ready flow control, explicit FSM, and selectable periodic or zero x-boundary.

---
 rtl/lga_ppg_pkg.sv | 33 +++
 rtl/lga_ppg_window_if.sv | 27 ++
 rtl/lga_ppg_window_row_bank.sv | 30 +++
 rtl/lga_ppg_window.sv | 248 ++++++++++++++++++++++++
 tb/tb_lga_ppg_window.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/lga_ppg_pkg.sv
// Shared types and constants for the lattice-gas propagation window block.
// The optional LGA_PPG_STAT_EN macro is consumed by the top, not by this package.
package lga_ppg_pkg;

  localparam int YW = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam int WIN_UP  = 0;
  localparam int WIN_MID = 1;
  localparam int WIN_DN  = 2;

  localparam int COL_L = 0;
  localparam int COL_C = 1;
  localparam int COL_R = 2;

  typedef logic [1:0] slot_t;

  // Mod-3 ring stepping for the row slot counters.
  function automatic slot_t slot_inc(slot_t s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic slot_t slot_dec(slot_t s);
    return (s == 2'd0) ? 2'd2 : s - 2'd1;
  endfunction

endpackage

// File: rtl/lga_ppg_window_if.sv
// Row-word input stream and 3x3 window output stream of lga_ppg_window.
interface lga_ppg_window_if #(
  parameter int DW = 64,
  parameter int AW = 8
);
  import lga_ppg_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [9*DW-1:0]   out_win;
  logic [AW-1:0]     out_x;
  logic [YW-1:0]     out_y;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_win, out_x, out_y
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_win, out_x, out_y
  );

endinterface

// File: rtl/lga_ppg_window_row_bank.sv
// One row slot: three synchronous RAM copies sharing a write port, each read
// at its own column address with a registered output.
module lga_row_bank
  import lga_ppg_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [DW-1:0]        wdata_i,
  input  logic                 re_i,
  input  logic [2:0][AW-1:0]   raddr_i,
  output logic [2:0][DW-1:0]   rdata_o
);

  for (genvar c = 0; c < 3; c++) begin : g_copy
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rd_q <= mem[raddr_i[c]];
    end

    assign rdata_o[c] = rd_q;
  end

endmodule

// File: rtl/lga_ppg_window.sv
// Three-row ring line buffer emitting a registered 3x3 window per lattice cell.
// Define LGA_PPG_STAT_EN to add the stall_cnt/word_cnt statistics outputs.
module lga_ppg_window
  import lga_ppg_pkg::*;
#(
  parameter int DW     = 64,
  parameter int AW     = 8,
  parameter int WRAP_X = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [AW-1:0]         dsizx,
  input  logic [YW-1:0]         dsizy,
  lga_ppg_window_if.slave       bus,
  output logic                  busy,
  output logic                  done
`ifdef LGA_PPG_STAT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           word_cnt
`endif
);

  state_e          state_q, state_d;
  logic [AW-1:0]   sx_q, sx_d;
  logic [YW-1:0]   sy_q, sy_d;
  logic [AW-1:0]   lx_q, lx_d;
  logic [YW:0]     ly_q, ly_d;
  logic [YW-1:0]   ey_q, ey_d;
  slot_t           sl_ld_q, sl_ld_d;
  slot_t           sl_em_q, sl_em_d;
  logic [AW-1:0]   ex_q, ex_d;
  logic            iss_done_q, iss_done_d;

  logic            in_acc, adv, issue, out_acc, last_out;
  logic [2:0][AW-1:0]        raddr;
  logic [2:0][2:0][DW-1:0]   rd;

  logic            vld_p1_q;
  logic [AW-1:0]   x_p1_q;
  logic [YW-1:0]   y_p1_q;
  slot_t           sl_p1_q;
  logic            upz_p1_q, dnz_p1_q, lz_p1_q, rz_p1_q;

  logic            vld_p2_q;
  logic [9*DW-1:0] win_p2_q;
  logic [AW-1:0]   x_p2_q;
  logic [YW-1:0]   y_p2_q;

  logic [2:0][2:0][DW-1:0]   rows;
  logic [9*DW-1:0]           win_d;

  function automatic logic [2:0][DW-1:0] pick_slot(slot_t s, logic [2:0][2:0][DW-1:0] r);
    case (s)
      2'd0:    return r[0];
      2'd1:    return r[1];
      default: return r[2];
    endcase
  endfunction

  assign in_acc   = (state_q == LOAD) && bus.in_valid;
  assign adv      = !vld_p2_q || bus.out_ready;
  assign issue    = (state_q == EMIT) && !iss_done_q && adv;
  assign out_acc  = vld_p2_q && bus.out_ready;
  assign last_out = out_acc && (x_p2_q == sx_q);

  always_comb begin
    state_d    = state_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    lx_d       = lx_q;
    ly_d       = ly_q;
    ey_d       = ey_q;
    sl_ld_d    = sl_ld_q;
    sl_em_d    = sl_em_q;
    ex_d       = ex_q;
    iss_done_d = iss_done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sx_d    = dsizx;
          sy_d    = dsizy;
          lx_d    = '0;
          ly_d    = '0;
          ey_d    = '0;
          sl_ld_d = 2'd0;
          sl_em_d = 2'd0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_acc) begin
          if (lx_q == sx_q) begin
            lx_d       = '0;
            ly_d       = ly_q + 1'b1;
            sl_ld_d    = slot_inc(sl_ld_q);
            ex_d       = '0;
            iss_done_d = 1'b0;
            // Row 0 is followed directly by row 1 so the first EMIT has its lower neighbour.
            state_d    = (ly_q == '0 && sy_q != '0) ? LOAD : EMIT;
          end else begin
            lx_d = lx_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (issue) begin
          if (ex_q == sx_q) iss_done_d = 1'b1;
          else              ex_d = ex_q + 1'b1;
        end
        if (last_out) begin
          ey_d       = ey_q + 1'b1;
          sl_em_d    = slot_inc(sl_em_q);
          ex_d       = '0;
          iss_done_d = 1'b0;
          if (ey_q == sy_q)              state_d = FIN;
          else if (ly_q <= {1'b0, sy_q}) state_d = LOAD;
          else                           state_d = EMIT;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      sx_q       <= '0;
      sy_q       <= '0;
      lx_q       <= '0;
      ly_q       <= '0;
      ey_q       <= '0;
      sl_ld_q    <= 2'd0;
      sl_em_q    <= 2'd0;
      ex_q       <= '0;
      iss_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      lx_q       <= lx_d;
      ly_q       <= ly_d;
      ey_q       <= ey_d;
      sl_ld_q    <= sl_ld_d;
      sl_em_q    <= sl_em_d;
      ex_q       <= ex_d;
      iss_done_q <= iss_done_d;
    end
  end

  // Stage p0: column addresses with periodic wrap; the zero boundary is masked later.
  assign raddr[COL_L] = (ex_q == '0)   ? sx_q : ex_q - 1'b1;
  assign raddr[COL_C] = ex_q;
  assign raddr[COL_R] = (ex_q == sx_q) ? '0   : ex_q + 1'b1;

  for (genvar b = 0; b < 3; b++) begin : g_bank
    lga_row_bank #(.DW(DW), .AW(AW)) u_bank (
      .clk_i   (CLK),
      .we_i    (in_acc && (sl_ld_q == slot_t'(b))),
      .waddr_i (lx_q),
      .wdata_i (bus.in_data),
      .re_i    (issue),
      .raddr_i (raddr),
      .rdata_o (rd[b])
    );
  end

  // Stage p1: RAM outputs valid; carry position and boundary flags alongside.
  always_ff @(posedge CLK) begin
    if (adv) begin
      x_p1_q   <= ex_q;
      y_p1_q   <= ey_q;
      sl_p1_q  <= sl_em_q;
      upz_p1_q <= (ey_q == '0);
      dnz_p1_q <= (ey_q == sy_q);
      lz_p1_q  <= (WRAP_X == 0) && (ex_q == '0);
      rz_p1_q  <= (WRAP_X == 0) && (ex_q == sx_q);
    end
  end

  assign rows[WIN_UP]  = upz_p1_q ? '0 : pick_slot(slot_dec(sl_p1_q), rd);
  assign rows[WIN_MID] = pick_slot(sl_p1_q, rd);
  assign rows[WIN_DN]  = dnz_p1_q ? '0 : pick_slot(slot_inc(sl_p1_q), rd);

  always_comb begin
    win_d = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!((c == COL_L && lz_p1_q) || (c == COL_R && rz_p1_q)))
          win_d[DW*(3*r+c) +: DW] = rows[r][c];
      end
    end
  end

  // Stage p2: registered window, held while the consumer stalls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      win_p2_q <= '0;
      x_p2_q   <= '0;
      y_p2_q   <= '0;
    end else if (adv) begin
      vld_p1_q <= issue;
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        win_p2_q <= win_d;
        x_p2_q   <= x_p1_q;
        y_p2_q   <= y_p1_q;
      end
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = vld_p2_q;
  assign bus.out_win   = win_p2_q;
  assign bus.out_x     = x_p2_q;
  assign bus.out_y     = y_p2_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);

`ifdef LGA_PPG_STAT_EN
  logic [31:0] stall_q, word_q;

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
      word_q  <= '0;
    end else if (state_q == IDLE && start) begin
      stall_q <= '0;
      word_q  <= '0;
    end else begin
      if (vld_p2_q && !bus.out_ready) stall_q <= sat_inc(stall_q);
      if (out_acc)                    word_q  <= sat_inc(word_q);
    end
  end

  assign stall_cnt = stall_q;
  assign word_cnt  = word_q;
`endif

endmodule

// File: tb/tb_lga_ppg_window.sv
// Directed bench: two instances (periodic and zero x-boundary) share the stimulus.
module tb_lga_ppg_window;
  import lga_ppg_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int LIMIT = 2000;

  logic            CLK = 1'b0;
  logic            RST;
  logic            start;
  logic [AW-1:0]   dsizx;
  logic [YW-1:0]   dsizy;
  logic            busy1, done1, busy0, done0;
`ifdef LGA_PPG_STAT_EN
  logic [31:0]     st1, wc1, st0, wc0;
`endif

  lga_ppg_window_if #(.DW(DW), .AW(AW)) b1 ();
  lga_ppg_window_if #(.DW(DW), .AW(AW)) b0 ();

  assign b0.in_valid  = b1.in_valid;
  assign b0.in_data   = b1.in_data;
  assign b0.out_ready = b1.out_ready;

  lga_ppg_window #(.DW(DW), .AW(AW), .WRAP_X(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .start(start), .dsizx(dsizx), .dsizy(dsizy),
    .bus(b1.slave), .busy(busy1), .done(done1)
`ifdef LGA_PPG_STAT_EN
    , .stall_cnt(st1), .word_cnt(wc1)
`endif
  );

  lga_ppg_window #(.DW(DW), .AW(AW), .WRAP_X(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .start(start), .dsizx(dsizx), .dsizy(dsizy),
    .bus(b0.slave), .busy(busy0), .done(done0)
`ifdef LGA_PPG_STAT_EN
    , .stall_cnt(st0), .word_cnt(wc0)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [9*DW-1:0] cw1 [$];
  logic [9*DW-1:0] cw0 [$];
  int              cx1 [$];
  int              cy1 [$];
  int              cx0 [$];
  int              cy0 [$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] model_win(int x, int y, int dx, int dy, bit wrap, bit cst);
    logic [9*DW-1:0] w;
    int xx, yy;
    bit z;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        yy = y + r - 1;
        xx = x + c - 1;
        z  = (yy < 0) || (yy > dy);
        if (xx < 0)  begin if (wrap) xx = dx; else z = 1'b1; end
        if (xx > dx) begin if (wrap) xx = 0;  else z = 1'b1; end
        if (!z) w[DW*(3*r+c) +: DW] = cst ? 16'hABCD : {yy[7:0], xx[7:0]};
      end
    end
    return w;
  endfunction

  task automatic drive_data(input int fx, input int fy, input bit cst);
    b1.in_data = cst ? 16'hABCD : {fy[7:0], fx[7:0]};
  endtask

  // bp: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = exactly five alternating stalls.
  task automatic run_frame(input int dx, input int dy, input int bp, input bit cst,
                           input bit spurious, input bit rst_mid);
    int fx, fy, cyc, dcnt, tail, st_left, n;
    bit acc, stalled, prev_lo;
    logic [9*DW-1:0] h_win;
    logic [AW-1:0]   h_x;
    logic [YW-1:0]   h_y;
    cw1.delete(); cw0.delete(); cx1.delete(); cy1.delete(); cx0.delete(); cy0.delete();
    fx = 0; fy = 0; cyc = 0; dcnt = 0; tail = -1; st_left = 5; stalled = 0; prev_lo = 0;
    h_win = '0; h_x = '0; h_y = '0;
    dsizx = AW'(dx);
    dsizy = YW'(dy);
    start = 1'b1;
    b1.in_valid  = 1'b1;
    b1.out_ready = 1'b1;
    drive_data(fx, fy, cst);
    @(posedge CLK); #1;
    start = 1'b0;
    dsizx = AW'(dx + 5);
    dsizy = YW'(dy + 7);
    while (cyc < LIMIT) begin
      @(negedge CLK);
      acc = b1.in_valid && b1.in_ready;
      if (stalled) begin
        chk("hold_valid", b1.out_valid, 1'b1);
        chk("hold_win", b1.out_win, h_win);
        chk("hold_x", b1.out_x, h_x);
        chk("hold_y", b1.out_y, h_y);
      end
      stalled = b1.out_valid && !b1.out_ready;
      if (stalled) begin
        h_win = b1.out_win; h_x = b1.out_x; h_y = b1.out_y;
      end
      if (b1.out_valid && b1.out_ready) begin
        cw1.push_back(b1.out_win); cx1.push_back(int'(b1.out_x)); cy1.push_back(int'(b1.out_y));
      end
      if (b0.out_valid && b0.out_ready) begin
        cw0.push_back(b0.out_win); cx0.push_back(int'(b0.out_x)); cy0.push_back(int'(b0.out_y));
      end
      if (rst_mid && cw1.size() == 5) begin
        #2 RST = 1'b1;
        #1;
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_valid1", b1.out_valid, 1'b0);
        chk("rst_busy0", busy0, 1'b0);
        chk("rst_valid0", b0.out_valid, 1'b0);
        chk("rst_in_ready", b1.in_ready, 1'b0);
        b1.in_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        return;
      end
      if (done1) begin
        dcnt++;
`ifdef LGA_PPG_STAT_EN
        if (bp == 2) begin
          chk("stall_cnt1", st1, 32'd5);
          chk("word_cnt1", wc1, 32'd12);
          chk("stall_cnt0", st0, 32'd5);
          chk("word_cnt0", wc0, 32'd12);
        end
`endif
        if (tail < 0) tail = 4;
      end
      if (tail > 0) tail--;
      if (tail == 0) break;
      @(posedge CLK); #1;
      if (acc) begin
        if (fx == dx) begin fx = 0; fy++; end
        else fx++;
        drive_data(fx, fy, cst);
      end
      start = spurious && (cyc == 3 || cyc == 20);
      case (bp)
        1: b1.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        2: begin
          b1.out_ready = !(b1.out_valid && st_left > 0 && !prev_lo);
          if (!b1.out_ready) st_left--;
          prev_lo = !b1.out_ready;
        end
        default: b1.out_ready = 1'b1;
      endcase
      cyc++;
    end
    chk("frame_in_budget", cyc < LIMIT, 1'b1);
    b1.in_valid  = 1'b0;
    b1.out_ready = 1'b1;
    start = 1'b0;
    n = (dx + 1) * (dy + 1);
    chk("done_pulses", dcnt, 1);
    chk("win_count1", cw1.size(), n);
    chk("win_count0", cw0.size(), n);
    for (int k = 0; k < cw1.size(); k++) begin
      chk($sformatf("x1[%0d]", k), cx1[k], k % (dx + 1));
      chk($sformatf("y1[%0d]", k), cy1[k], k / (dx + 1));
      chk($sformatf("win1[%0d]", k), cw1[k], model_win(k % (dx + 1), k / (dx + 1), dx, dy, 1'b1, cst));
    end
    for (int k = 0; k < cw0.size(); k++) begin
      chk($sformatf("x0[%0d]", k), cx0[k], k % (dx + 1));
      chk($sformatf("win0[%0d]", k), cw0[k], model_win(k % (dx + 1), k / (dx + 1), dx, dy, 1'b0, cst));
    end
  endtask

  initial begin
    RST = 1'b1;
    start = 1'b0;
    dsizx = '0;
    dsizy = '0;
    b1.in_valid  = 1'b0;
    b1.in_data   = '0;
    b1.out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_busy", busy1, 1'b0);
    chk("reset_done", done1, 1'b0);
    chk("reset_in_ready", b1.in_ready, 1'b0);
    chk("reset_out_valid", b1.out_valid, 1'b0);
    chk("reset_out_win", b1.out_win, '0);
    chk("reset_out_x", b1.out_x, '0);
    chk("reset_out_y", b1.out_y, '0);
    chk("reset_busy0", busy0, 1'b0);
    RST = 1'b0;
    @(posedge CLK); #1;

    run_frame(3, 2, 0, 1'b0, 1'b0, 1'b0);
    chk("win_x0_y1", cw1[4], 144'h0201_0200_0203_0101_0100_0103_0001_0000_0003);
    chk("zero_x0_y0", cw0[0], 144'h0101_0100_0000_0001_0000_0000_0000_0000_0000);
    chk("zero_x3_y2", cw0[11], 144'h0000_0000_0000_0000_0203_0202_0000_0103_0102);

    run_frame(3, 2, 1, 1'b0, 1'b0, 1'b0);

    run_frame(0, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("degen_wrap", cw1[0], 144'h0000_0000_0000_ABCD_ABCD_ABCD_0000_0000_0000);
    chk("degen_zero", cw0[0], 144'h0000_0000_0000_0000_ABCD_0000_0000_0000_0000);

    run_frame(3, 2, 0, 1'b0, 1'b0, 1'b1);
    @(posedge CLK); #1;
    chk("post_rst_busy", busy1, 1'b0);
    run_frame(3, 2, 1, 1'b0, 1'b1, 1'b0);

    run_frame(3, 2, 2, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
